boot_loader: RTL and testbench
==============================

Name: boot_loader

Overview:
- Sits directly upstream of the single-cycle core top level.
- Receives a byte stream over a valid/ready handshake, e.g. from a UART receiver.
- Assembles big-endian 32-bit instruction words and writes them into instruction memory through a dedicated write port.
- Holds the core in reset until the image is fully loaded and its checksum has been verified, then releases it.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of the first word; must be 4-aligned, matches the core's reset PC.
MAX_WORDS, 1024, instruction memory capacity in words; any larger count is rejected.

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
byte_in  input  8  incoming data byte
byte_valid  input  1  byte_in is valid this cycle
byte_ready  output  1  loader can accept a byte this cycle
im_we  output  1  instruction memory write strobe, one cycle per word
im_addr  output  32  instruction memory byte address
im_wdata  output  32  instruction word to write
cpu_rst_n  output  1  active-low reset driven into the core top level
done  output  1  image loaded and checksum verified; core running
err  output  1  sticky error flag: oversize count or checksum mismatch

Behaviour:
- Reset on rising clk edge with rst_n=0. All state returns to CNT_HI regardless of current state, including mid-word or mid-stream.
- Reset values: im_we=0, im_addr=BASE_ADDR, im_wdata=0, cpu_rst_n=0, done=0, err=0. Word counter, byte index, assembly register and checksum all clear to 0.
- Handshake: a byte is accepted on any cycle where byte_valid && byte_ready.
  - byte_ready is a registered-state decode: 1 in CNT_HI, CNT_LO, DATA and CHK; 0 in RUN and ERR.
  - byte_ready does not depend combinationally on byte_valid.
- Stream format: count_hi, count_lo (16-bit word count N, big-endian), then 4*N payload bytes, then one checksum byte.
  - Each word arrives MSB first.
  - Checksum byte = XOR of all 4*N payload bytes. Count bytes are excluded.
- CNT_HI: on accept, latch count[15:8] and go to CNT_LO.
- CNT_LO: on accept, evaluate N = {count[15:8], byte_in}:
  - N > MAX_WORDS: go to ERR.
  - N == 0: go to CHK; expected checksum is 0.
  - otherwise go to DATA.
- DATA:
  - Each accepted byte shifts into the assembly register (new byte enters at the LSB) and is XORed into the running checksum.
  - On the 4th byte of a word, im_wdata is registered with the full word and im_we=1 for exactly one cycle, the cycle after that handshake.
  - im_addr = BASE_ADDR + 4*i for word i (0-based), presented in the same cycle as im_we.
  - im_addr increments by 4 after each write and wraps modulo 2^32.
  - After word N-1 is written, go to CHK.
  - A byte accepted in the cycle im_we is high is handled normally; back-to-back bytes every cycle are supported with no stall.
- CHK: on accept, compare byte_in with the running checksum:
  - equal: go to RUN, with cpu_rst_n=1 and done=1 starting the next cycle.
  - different: go to ERR.
- RUN: terminal until rst_n=0. byte_ready=0, im_we=0, and byte_valid is ignored.
- ERR: terminal until rst_n=0. err=1, cpu_rst_n=0, done=0, byte_ready=0.
  - Words already written before an error remain in memory; the core never leaves reset.
- cpu_rst_n, done and err are registered outputs and glitch-free. done and err are never both 1.
- byte_valid held low stalls the loader indefinitely in the current state. There is no timeout.

Test Plan:
- Load N=2, words 32'h2001_0005 and 32'h0000_0008, checksum 8'h2C (XOR of 20,01,00,05,00,00,00,08), one byte per cycle -> im_we pulses at im_addr 0x0 then 0x4 with those im_wdata values; done=1 and cpu_rst_n=1 the cycle after the checksum byte is accepted.
- N=0, then checksum 8'h00 -> no im_we pulses; done=1. The same with checksum 8'h01 instead -> err=1, cpu_rst_n stays 0.
- Count bytes 8'h04, 8'h01 (N=1025, greater than MAX_WORDS=1024) -> err=1 the next cycle, byte_ready=0, no writes.
- N=1, word 32'hDEAD_BEEF with byte_valid toggling 1/0 on alternate cycles, then the correct checksum 8'h22 -> single write of 32'hDEADBEEF at im_addr 0x0; done=1.
- Pull rst_n low after 2 payload bytes of a load, then send a full valid N=1 image -> outputs return to reset values; the new word is written at BASE_ADDR and done=1. No residue from the aborted load.
- In RUN, drive byte_valid=1 with arbitrary bytes for 10 cycles -> byte_ready=0, im_we=0, done and cpu_rst_n stay 1.

Source files
------------

// File: rtl/boot_loader.sv
// Byte-stream boot loader: reads a counted, checksummed image of big-endian words
// into instruction memory and keeps the core in reset until the image is verified.
module boot_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          MAX_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic        im_we,
   output logic [31:0] im_addr,
   output logic [31:0] im_wdata,
   output logic        cpu_rst_n,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {CNT_HI, CNT_LO, DATA, CHK, RUN, ERR} state_t;

   localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

   state_t      state, state_nxt;
   logic [7:0]  cnt_hi;
   logic [15:0] n_words;
   logic [15:0] word_idx;
   logic [1:0]  byte_idx;
   logic [23:0] asm_reg;
   logic [7:0]  csum;
   logic        accept;
   logic        last_byte;
   logic        last_word;
   logic [16:0] n_cat;

   assign byte_ready = (state == CNT_HI) || (state == CNT_LO) || (state == DATA) || (state == CHK);
   assign accept     = byte_valid && byte_ready;
   assign last_byte  = (byte_idx == 2'd3);
   assign last_word  = ((word_idx + 16'd1) == n_words);
   // 17 bits so a count above MAX_WORDS compares correctly for any MAX_WORDS
   assign n_cat      = {1'b0, cnt_hi, byte_in};

   always_ff @(posedge clk) begin
      if (!rst_n) state <= CNT_HI;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         CNT_HI: if (accept) state_nxt = CNT_LO;
         CNT_LO: if (accept) begin
            if (n_cat > MAX_N)      state_nxt = ERR;
            else if (n_cat == 17'd0) state_nxt = CHK;
            else                    state_nxt = DATA;
         end
         DATA:   if (accept && last_byte && last_word) state_nxt = CHK;
         CHK:    if (accept) state_nxt = (byte_in == csum) ? RUN : ERR;
         default: state_nxt = state;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_hi    <= '0;
         n_words   <= '0;
         word_idx  <= '0;
         byte_idx  <= '0;
         asm_reg   <= '0;
         csum      <= '0;
         im_we     <= 1'b0;
         im_addr   <= BASE_ADDR;
         im_wdata  <= '0;
         cpu_rst_n <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         im_we <= 1'b0;
         if (im_we) im_addr <= im_addr + 32'd4;
         // status flags follow the next state so they change exactly on entry
         cpu_rst_n <= (state_nxt == RUN);
         done      <= (state_nxt == RUN);
         err       <= (state_nxt == ERR);
         if (accept) begin
            case (state)
               CNT_HI: cnt_hi  <= byte_in;
               CNT_LO: n_words <= n_cat[15:0];
               DATA: begin
                  asm_reg  <= {asm_reg[15:0], byte_in};
                  csum     <= csum ^ byte_in;
                  byte_idx <= byte_idx + 2'd1;
                  if (last_byte) begin
                     im_wdata <= {asm_reg, byte_in};
                     im_we    <= 1'b1;
                     word_idx <= word_idx + 16'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_boot_loader.sv
// Directed and randomized image loads checked against a queue-based model of the
// stream format (expected writes, checksum, pass/fail outcome).
module tb_boot_loader;

   localparam logic [31:0] BASE = 32'h0000_0000;
   localparam int          MAXW = 1024;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  byte_in = 8'h00;
   logic        byte_valid = 1'b0;
   logic        byte_ready;
   logic        im_we;
   logic [31:0] im_addr;
   logic [31:0] im_wdata;
   logic        cpu_rst_n;
   logic        done;
   logic        err;

   int n_assert = 0;
   int n_fail   = 0;

   logic [31:0] img[$];
   logic [63:0] wr_q[$];

   boot_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
      .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
      .byte_ready(byte_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
      .cpu_rst_n(cpu_rst_n), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // every cycle with im_we high is one memory write
   always @(negedge clk) if (rst_n && im_we) wr_q.push_back({im_addr, im_wdata});

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] model_csum();
      logic [7:0] x = 8'h00;
      foreach (img[i]) x = x ^ img[i][31:24] ^ img[i][23:16] ^ img[i][15:8] ^ img[i][7:0];
      return x;
   endfunction

   task automatic send(input logic [7:0] b, input int gap);
      byte_in = b; byte_valid = 1'b1;
      @(posedge clk); #1;
      byte_valid = 1'b0; byte_in = 8'($urandom);
      repeat (gap) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; byte_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_we", im_we, 1'b0);
      chk("rst_addr", im_addr, BASE);
      chk("rst_wdata", im_wdata, 32'h0);
      chk("rst_cpu", cpu_rst_n, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_ready", byte_ready, 1'b1);
      rst_n = 1'b1;
      wr_q.delete();
   endtask

   task automatic run_load(input logic [7:0] cs, input int gap);
      logic [15:0] n = 16'(img.size());
      send(n[15:8], gap);
      send(n[7:0], gap);
      foreach (img[i]) begin
         send(img[i][31:24], gap); send(img[i][23:16], gap);
         send(img[i][15:8], gap);  send(img[i][7:0], gap);
      end
      send(cs, 0);
   endtask

   // checked in the cycle right after the checksum byte was accepted
   task automatic verify(input string tag, input logic [7:0] cs);
      logic ok = (cs == model_csum());
      chk({tag, "_done"}, done, ok);
      chk({tag, "_cpu"}, cpu_rst_n, ok);
      chk({tag, "_err"}, err, !ok);
      chk({tag, "_ready"}, byte_ready, 1'b0);
      repeat (2) @(posedge clk); #1;
      chk({tag, "_nwr"}, wr_q.size(), img.size());
      foreach (img[i]) if (i < wr_q.size())
         chk({tag, "_wr"}, wr_q[i], {BASE + 32'(4 * i), img[i]});
   endtask

   initial begin
      logic [7:0] cs;

      // basic N=2 image, back-to-back bytes
      do_reset();
      img = '{32'h2001_0005, 32'h0000_0008};
      run_load(8'h2C, 0);
      verify("n2", 8'h2C);

      // running core ignores further bytes
      for (int i = 0; i < 10; i++) begin
         byte_in = 8'($urandom); byte_valid = 1'b1;
         @(posedge clk); #1;
         chk("run_ready", byte_ready, 1'b0);
         chk("run_we", im_we, 1'b0);
         chk("run_done", done, 1'b1);
         chk("run_cpu", cpu_rst_n, 1'b1);
      end
      byte_valid = 1'b0;
      chk("run_nwr", wr_q.size(), 2);

      // empty image, good and bad checksum
      do_reset();
      img.delete();
      run_load(8'h00, 0);
      verify("n0_ok", 8'h00);
      do_reset();
      run_load(8'h01, 0);
      verify("n0_bad", 8'h01);

      // oversize count
      do_reset();
      send(8'h04, 0); send(8'h01, 0);
      chk("big_err", err, 1'b1);
      chk("big_ready", byte_ready, 1'b0);
      chk("big_done", done, 1'b0);
      chk("big_cpu", cpu_rst_n, 1'b0);
      repeat (8) send(8'($urandom), 0);
      chk("big_nwr", wr_q.size(), 0);
      chk("big_err2", err, 1'b1);

      // single word with valid toggling every other cycle
      do_reset();
      img = '{32'hDEAD_BEEF};
      run_load(8'h22, 1);
      verify("beef", 8'h22);

      // reset in mid-word, then a fresh image
      do_reset();
      send(8'h00, 0); send(8'h02, 0); send(8'hAA, 0); send(8'h55, 0);
      do_reset();
      img = '{$urandom};
      cs = model_csum();
      run_load(cs, 0);
      verify("abort", cs);

      // randomized images, gaps and occasional corrupted checksums
      for (int t = 0; t < 6; t++) begin
         do_reset();
         img.delete();
         repeat ($urandom_range(1, 6)) img.push_back($urandom);
         cs = model_csum();
         if ($urandom_range(0, 2) == 0) cs = cs ^ 8'($urandom_range(1, 255));
         run_load(cs, $urandom_range(0, 2));
         verify("rand", cs);
      end

      // largest legal image
      do_reset();
      img.delete();
      repeat (MAXW) img.push_back($urandom);
      cs = model_csum();
      run_load(cs, 0);
      verify("max", cs);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
